imem_responder: RTL and testbench



---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_responder_if.sv | 28 ++
 rtl/imem_rsp_fifo.sv | 66 ++++++
 rtl/imem_responder.sv | 112 +++++++++++
 tb/tb_imem_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types, constants and address checking for the
// instruction-memory responder.
package imem_pkg;

    // Canonical RISC-V NOP (ADDI x0,x0,0).
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // One response word as it travels through the pipeline and buffer.
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } imem_rsp_t;

    // Access fault: not word aligned, or beyond the last word of a
    // depth-word memory.
    function automatic logic imem_addr_err(input logic [31:0] addr, input int depth);
        logic [33:0] limit;
        limit = 34'(depth) << 2;
        return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response channels plus the program
// load write port. Signal names are from the responder's point of view.
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high. Once valid is raised the sender holds it and its
// payload stable until that edge; ready may change freely.
interface imem_responder_if;
    logic        i_reqValid;
    logic        o_reqReady;
    logic [31:0] i_reqAddr;
    logic        o_rspValid;
    logic        i_rspReady;
    logic [31:0] o_rspData;
    logic        o_rspErr;
    logic        i_wrEn;
    logic [31:0] i_wrAddr;
    logic [31:0] i_wrData;

    modport slave (
        input  i_reqValid, i_reqAddr, i_rspReady, i_wrEn, i_wrAddr, i_wrData,
        output o_reqReady, o_rspValid, o_rspData, o_rspErr
    );

    modport master (
        output i_reqValid, i_reqAddr, i_rspReady, i_wrEn, i_wrAddr, i_wrData,
        input  o_reqReady, o_rspValid, o_rspData, o_rspErr
    );
endinterface

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo: synchronous response buffer with push/pop/full/empty.
// The head entry is presented combinationally; storage resets to zero so
// the head reads as zero straight out of reset.
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int RSP_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  imem_rsp_t push_data,
    input  logic      pop,
    output imem_rsp_t head,
    output logic      full,
    output logic      empty
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    imem_rsp_t       store [RSP_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_pop;
    logic            do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(RSP_DEPTH));
    assign head    = store[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (do_push) begin
                store[wr_ptr] <= push_data;
                wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Credits upstream must make a push into a full, non-draining buffer impossible.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory slave for the CPU fetch port.
// Requests are accepted against a credit counter, read the memory array,
// travel a fixed LATENCY-stage pipeline and land in a response buffer.
// Optional build macro IMEM_NOP_ON_ERR_EN: faulting fetches return the
// RISC-V NOP instead of zero (o_rspErr is still raised).
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 2,
    parameter int RSP_DEPTH = 4
) (
    input logic              i_clock,
    input logic              i_reset,
    imem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RSP_DEPTH) + 1;

`ifdef IMEM_NOP_ON_ERR_EN
    localparam logic [31:0] ERR_DATA = RV_NOP;
`else
    localparam logic [31:0] ERR_DATA = 32'h0000_0000;
`endif

    logic [31:0]  mem [DEPTH];
    logic [CW-1:0] credits;
    logic [LATENCY-1:0] pipe_v;
    logic [31:0]  pipe_d [LATENCY];
    logic         pipe_e [LATENCY];

    logic          accept;
    logic          pop;
    logic          req_err;
    logic          wr_err;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] wr_idx;
    imem_rsp_t     fifo_head;
    imem_rsp_t     fifo_in;
    logic          fifo_full;
    logic          fifo_empty;

    assign req_err = imem_addr_err(bus.i_reqAddr, DEPTH);
    assign wr_err  = imem_addr_err(bus.i_wrAddr, DEPTH);
    assign req_idx = bus.i_reqAddr[AW+1:2];
    assign wr_idx  = bus.i_wrAddr[AW+1:2];

    // Ready depends only on the registered credit count (and reset), so
    // there is no combinational path from i_rspReady to o_reqReady.
    assign bus.o_reqReady = !i_reset && (credits < CW'(RSP_DEPTH));
    assign accept         = bus.i_reqValid && bus.o_reqReady;
    assign pop            = bus.o_rspValid && bus.i_rspReady;

    // Credit counter: one credit per request between accept and pop.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            credits <= '0;
        end else if (accept && !pop) begin
            credits <= credits + 1'b1;
        end else if (pop && !accept) begin
            credits <= credits - 1'b1;
        end
    end

    // Program-load writes; the nonblocking update makes a same-edge read see the old word.
    always_ff @(posedge i_clock) begin
        if (bus.i_wrEn && !wr_err) begin
            mem[wr_idx] <= bus.i_wrData;
        end
    end

    // Read pipeline: stage 0 captures the memory word, later stages shift it along.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            pipe_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_d[i] <= '0;
                pipe_e[i] <= 1'b0;
            end
        end else begin
            pipe_v[0] <= accept;
            if (accept) begin
                pipe_d[0] <= req_err ? ERR_DATA : mem[req_idx];
                pipe_e[0] <= req_err;
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
                pipe_e[i] <= pipe_e[i-1];
            end
        end
    end

    assign fifo_in.data = pipe_d[LATENCY-1];
    assign fifo_in.err  = pipe_e[LATENCY-1];

    imem_rsp_fifo #(.RSP_DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (i_clock),
        .rst       (i_reset),
        .push      (pipe_v[LATENCY-1]),
        .push_data (fifo_in),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.o_rspValid = !fifo_empty;
    assign bus.o_rspData  = fifo_head.data;
    assign bus.o_rspErr   = fifo_head.err;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed and random fetch traffic against
// imem_responder, checked every cycle by a queue-based reference model.
module tb_imem_responder;
    localparam int DEPTH     = 1024;
    localparam int LATENCY   = 2;
    localparam int RSP_DEPTH = 4;

`ifdef IMEM_NOP_ON_ERR_EN
    localparam logic [31:0] ERR_WORD = 32'h0000_0013;
`else
    localparam logic [31:0] ERR_WORD = 32'h0000_0000;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_responder_if bus();

    imem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // ---------------- model state / scoreboard ----------------
    logic [31:0] mem_m [DEPTH];
    logic [31:0] exp_q[$];
    logic        exp_e_q[$];
    longint      rdy_q[$];
    logic [31:0] got_q[$];
    logic        got_e_q[$];
    int          total = 0;
    int          bad = 0;
    int          acc_count = 0;
    longint      t = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic        prev_err;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, got, exp, t);
        end
    endfunction

    function automatic logic addr_bad(logic [31:0] a);
        return (a % 4 != 0) || (longint'(a) >= 4 * DEPTH);
    endfunction

    // Compare process: outputs checked at each falling edge, then the
    // model advances for the rising edge that follows.
    always @(negedge clk) begin
        logic exp_v;
        logic [31:0] d;
        logic e;
        t++;
        if (rst) begin
            chk("rst_rsp_valid", 32'(bus.o_rspValid), 32'd0);
            chk("rst_req_ready", 32'(bus.o_reqReady), 32'd0);
            exp_q.delete();
            exp_e_q.delete();
            rdy_q.delete();
            stall_prev = 1'b0;
        end else begin
            exp_v = (exp_q.size() > 0) && (rdy_q[0] <= t);
            chk("rsp_valid", 32'(bus.o_rspValid), 32'(exp_v));
            chk("req_ready", 32'(bus.o_reqReady), 32'(exp_q.size() < RSP_DEPTH));
            if (bus.o_rspValid && exp_v) begin
                chk("rsp_data", bus.o_rspData, exp_q[0]);
                chk("rsp_err", 32'(bus.o_rspErr), 32'(exp_e_q[0]));
            end
            if (stall_prev && bus.o_rspValid) begin
                chk("stall_data", bus.o_rspData, prev_data);
                chk("stall_err", 32'(bus.o_rspErr), 32'(prev_err));
            end
            // Pop at the coming edge.
            if (bus.o_rspValid && bus.i_rspReady) begin
                got_q.push_back(bus.o_rspData);
                got_e_q.push_back(bus.o_rspErr);
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(exp_e_q.pop_front());
                    void'(rdy_q.pop_front());
                end
            end
            // Accept at the coming edge: read the model memory before any write.
            if (bus.i_reqValid && bus.o_reqReady) begin
                e = addr_bad(bus.i_reqAddr);
                d = e ? ERR_WORD : mem_m[(bus.i_reqAddr / 4) % DEPTH];
                exp_q.push_back(d);
                exp_e_q.push_back(e);
                rdy_q.push_back(t + 1 + LATENCY);
                acc_count++;
            end
            if (bus.i_wrEn && !addr_bad(bus.i_wrAddr)) begin
                mem_m[(bus.i_wrAddr / 4) % DEPTH] = bus.i_wrData;
            end
            stall_prev = bus.o_rspValid && !bus.i_rspReady;
            prev_data  = bus.o_rspData;
            prev_err   = bus.o_rspErr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        bus.i_wrEn   = 1'b1;
        bus.i_wrAddr = a;
        bus.i_wrData = d;
        step();
        bus.i_wrEn   = 1'b0;
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic req(logic [31:0] a);
        logic taken;
        bus.i_reqValid = 1'b1;
        bus.i_reqAddr  = a;
        taken = 1'b0;
        for (int i = 0; i < 100 && !taken; i++) begin
            taken = bus.o_reqReady;
            step();
        end
        if (!taken) chk("req_accept_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int a0;
        int cyc;
        logic acc;
        logic [31:0] words [4];
        words[0] = 32'h0000_0093;
        words[1] = 32'h0010_0113;
        words[2] = 32'h0020_0193;
        words[3] = 32'h0030_0213;

        rst = 1'b1;
        bus.i_reqValid = 1'b0;
        bus.i_reqAddr  = '0;
        bus.i_rspReady = 1'b0;
        bus.i_wrEn     = 1'b0;
        bus.i_wrAddr   = '0;
        bus.i_wrData   = '0;
        #1;
        chk("reset_rsp_valid", 32'(bus.o_rspValid), 32'd0);
        chk("reset_rsp_data", bus.o_rspData, 32'd0);
        chk("reset_rsp_err", 32'(bus.o_rspErr), 32'd0);
        chk("reset_req_ready", 32'(bus.o_reqReady), 32'd0);
        idle(2);
        rst = 1'b0;
        #1;
        chk("release_req_ready", 32'(bus.o_reqReady), 32'd1);

        // Preload program and scratch words.
        for (int k = 0; k < 4; k++) wr(32'(4 * k), words[k]);
        wr(32'h10, 32'h1111_1111);
        for (int k = 5; k < 16; k++) wr(32'(4 * k), 32'hA000_0000 + 32'(k));

        // Back-to-back fetch with the consumer always ready.
        bus.i_rspReady = 1'b1;
        base = got_q.size();
        for (int k = 0; k < 4; k++) req(32'(4 * k));
        bus.i_reqValid = 1'b0;
        idle(6);
        for (int k = 0; k < 4; k++) chk("b2b_data", got_q[base + k], words[k]);
        chk("b2b_count", 32'(got_q.size() - base), 32'd4);

        // Fill all credits with the consumer stalled.
        bus.i_rspReady = 1'b0;
        base = got_q.size();
        a0 = acc_count;
        bus.i_reqValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.i_reqAddr = 32'(4 * (5 + i));
            step();
        end
        chk("full_accepts", 32'(acc_count - a0), 32'd4);
        chk("full_req_ready", 32'(bus.o_reqReady), 32'd0);
        bus.i_rspReady = 1'b1;
        step();
        bus.i_rspReady = 1'b0;
        chk("pop_req_ready", 32'(bus.o_reqReady), 32'd1);
        step();
        bus.i_reqValid = 1'b0;
        bus.i_rspReady = 1'b1;
        idle(12);
        chk("full_pops", 32'(got_q.size() - base), 32'd5);
        for (int k = 0; k < 4; k++) chk("full_data", got_q[base + k], 32'hA000_0005 + 32'(k));
        chk("full_data_after_pop", got_q[base + 4], 32'hA000_000C);

        // Access faults: misaligned and one past the end.
        base = got_q.size();
        req(32'h2);
        req(32'h1000);
        bus.i_reqValid = 1'b0;
        idle(6);
        chk("err_misalign_data", got_q[base], ERR_WORD);
        chk("err_misalign_flag", 32'(got_e_q[base]), 32'd1);
        chk("err_range_data", got_q[base + 1], ERR_WORD);
        chk("err_range_flag", 32'(got_e_q[base + 1]), 32'd1);

        // Read-before-write on the same word in the same cycle.
        base = got_q.size();
        bus.i_wrEn   = 1'b1;
        bus.i_wrAddr = 32'h10;
        bus.i_wrData = 32'hDEAD_BEEF;
        req(32'h10);
        bus.i_wrEn = 1'b0;
        req(32'h10);
        bus.i_reqValid = 1'b0;
        idle(6);
        chk("rbw_old", got_q[base], 32'h1111_1111);
        chk("rbw_new", got_q[base + 1], 32'hDEAD_BEEF);

        // Asynchronous reset with three responses buffered.
        bus.i_rspReady = 1'b0;
        for (int k = 0; k < 3; k++) req(32'(4 * k));
        bus.i_reqValid = 1'b0;
        idle(3);
        chk("pre_reset_valid", 32'(bus.o_rspValid), 32'd1);
        base = got_q.size();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", 32'(bus.o_rspValid), 32'd0);
        chk("async_reset_ready", 32'(bus.o_reqReady), 32'd0);
        idle(2);
        rst = 1'b0;
        #1;
        chk("post_reset_ready", 32'(bus.o_reqReady), 32'd1);
        bus.i_rspReady = 1'b1;
        idle(6);
        chk("no_stale", 32'(got_q.size() - base), 32'd0);
        req(32'h0);
        bus.i_reqValid = 1'b0;
        idle(6);
        chk("mem_retained", got_q[base], 32'h0000_0093);

        // Random traffic; request payload held while waiting for ready.
        a0 = acc_count;
        cyc = 0;
        bus.i_reqValid = 1'b0;
        while ((acc_count - a0) < 1000 && cyc < 20000) begin
            if (!bus.i_reqValid) begin
                int r;
                bus.i_reqValid = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 19);
                if (r < 16)      bus.i_reqAddr = 32'(4 * r);
                else if (r < 18) bus.i_reqAddr = 32'(4 * r + 1);
                else             bus.i_reqAddr = 32'h1000 + 32'(4 * r);
            end
            bus.i_rspReady = ($urandom_range(0, 3) != 0);
            bus.i_wrEn     = ($urandom_range(0, 7) == 0);
            bus.i_wrAddr   = 32'(4 * $urandom_range(5, 15));
            bus.i_wrData   = $urandom;
            acc = bus.i_reqValid && bus.o_reqReady;
            step();
            if (acc) bus.i_reqValid = 1'b0;
            cyc++;
        end
        bus.i_reqValid = 1'b0;
        bus.i_wrEn     = 1'b0;
        bus.i_rspReady = 1'b1;
        chk("rand_accepts", 32'((acc_count - a0) >= 1000), 32'd1);
        idle(20);
        chk("final_drained", 32'(exp_q.size()), 32'd0);
        chk("final_rsp_valid", 32'(bus.o_rspValid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
